ahb_arbiter_rr: RTL and testbench
=================================

AHB_ARBITER_RR -- requirements
Module: ahb_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of bus masters; legal range 2..15.
REQ-002 Parameter ARB_MODE, default 0: arbitration policy; 0 = round-robin, 1 = fixed priority with lowest index highest.
REQ-003 Parameter DEFAULT_MASTER, default 0: master granted when nothing requests; legal range 0..NUM_MASTERS-1.
REQ-004 Parameter INCR_MAX_BEATS, default 16: beat limit for undefined-length INCR bursts before forced re-arbitration; legal range 1..255.
REQ-005 Localparam MW = clog2(NUM_MASTERS+1); code NUM_MASTERS is the dummy master.
REQ-006 HCLK  in  1  single clock; all state on rising edge.
REQ-007 HRESETn  in  1  asynchronous, active-low reset.
REQ-008 HBUSREQ  in  NUM_MASTERS  per-master bus request.
REQ-009 HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
REQ-010 HSPLIT  in  NUM_MASTERS  OR of slave split-resume bits; bit i releases master i.
REQ-011 HTRANS  in  2  current transfer type (IDLE/BUSY/NONSEQ/SEQ).
REQ-012 HBURST  in  3  current burst type.
REQ-013 HRESP  in  2  slave response (OKAY/ERROR/RETRY/SPLIT).
REQ-014 HREADY  in  1  transfer-complete strobe.
REQ-015 HGRANT  out  NUM_MASTERS  one-hot grant, or all-zero for dummy master.
REQ-016 HMASTER  out  MW  index of master owning the address phase.
REQ-017 HMASTLOCK  out  1  current address phase is locked.

Function
REQ-018 Internal state: grant index G (MW bits), split mask M (NUM_MASTERS bits), round-robin pointer P (index of last granted master), beat counter C (8 bits).
REQ-019 HGRANT is decoded from G combinationally; HGRANT = 0 when G = dummy.
REQ-020 C loads on accepted NONSEQ (HREADY=1): SINGLE->1, INCR4/WRAP4->4, INCR8/WRAP8->8, INCR16/WRAP16->16, INCR->INCR_MAX_BEATS; C decrements by 1 on each accepted SEQ while C>0, never wraps below 0; BUSY and HREADY=0 hold C; IDLE clears C to 0.
REQ-021 Arbitration point: HREADY=1 and one of: HTRANS=IDLE; accepted beat with C=1 before update; owner HBUSREQ=0 while HTRANS not in {SEQ, BUSY}; G = dummy.
REQ-022 At an arbitration point, if G's HLOCK=1 and G's HBUSREQ=1, G is retained.
REQ-023 Otherwise candidates = HBUSREQ & ~M; ARB_MODE=0 picks the first candidate searching P+1, P+2, ... modulo NUM_MASTERS; ARB_MODE=1 picks the lowest-index candidate.
REQ-024 If no candidate, G = DEFAULT_MASTER when M[DEFAULT_MASTER]=0, else G = dummy.
REQ-025 P updates to the new G only when a real master (not dummy) is newly granted by candidate selection.
REQ-026 HRESP=SPLIT with HREADY=1: set M[HMASTER] and force an arbitration point that excludes that master, overriding lock.
REQ-027 HRESP=RETRY: G is retained; C cleared to 0.
REQ-028 HRESP=ERROR: C is unaffected; arbitration proceeds per REQ-021.
REQ-029 HSPLIT[i]=1 clears M[i] next cycle; a simultaneous set and clear of the same bit resolves to clear.
REQ-030 HMASTER and HMASTLOCK register G and G's HLOCK on each rising edge with HREADY=1; both hold while HREADY=0, giving one-cycle grant-to-address-phase latency.
REQ-031 HGRANT changes only at arbitration points or on SPLIT; it never changes while HREADY=0.
REQ-032 A master whose M bit is set is never granted, including as the default master.

Reset
REQ-033 Asynchronous assertion of HRESETn=0 sets G=DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0, M=0, C=0, P=NUM_MASTERS-1 immediately, and abandons any in-flight burst.
REQ-034 After release, first candidate selection in round-robin mode starts at master 0.

Verification
REQ-035 N=4, RR; HBUSREQ=1111 with SINGLE transfers -> grant order 0,1,2,3,0 on consecutive arbitration points.
REQ-036 ARB_MODE=1; HBUSREQ=0110 -> HGRANT=0010; master 1 drops its request -> HGRANT=0100.
REQ-037 Master 2 runs INCR8 with HLOCK=1 and master 0 requests -> HGRANT stays 0100 for all 8 beats; HMASTLOCK=1 for each beat; master 0 is granted after the last beat.
REQ-038 SPLIT response to master 1 -> M=0010; master 1 is not granted despite request; HSPLIT=0010 -> M=0000 and master 1 is eligible next arbitration.
REQ-039 INCR with INCR_MAX_BEATS=4 and a competing request -> re-arbitration after beat 4; HREADY=0 held for 3 cycles -> HMASTER and HGRANT unchanged.
REQ-040 All masters split and none requesting -> HGRANT=0 and HMASTER=4 (dummy); HRESETn pulsed mid-burst -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter: round-robin or fixed-priority grant with locked-transfer retention,
// split masking, and a forced re-arbitration limit on undefined-length INCR bursts.
module ahb_arbiter_rr #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned ARB_MODE       = 0,
   parameter int unsigned DEFAULT_MASTER = 0,
   parameter int unsigned INCR_MAX_BEATS = 16,
   localparam int unsigned MW            = $clog2(NUM_MASTERS + 1)
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [NUM_MASTERS-1:0] HSPLIT,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic [1:0]             HRESP,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]          HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransBusy   = 2'b01;
   localparam logic [1:0] TransNonseq = 2'b10;
   localparam logic [1:0] TransSeq    = 2'b11;
   localparam logic [1:0] RespRetry   = 2'b10;
   localparam logic [1:0] RespSplit   = 2'b11;
   localparam logic [MW-1:0] Dummy    = MW'(NUM_MASTERS);

   logic [MW-1:0]          g_q, g_d, p_q, p_d, hmaster_q, hmaster_d;
   logic [NUM_MASTERS-1:0] m_q, m_d;
   logic [7:0]             c_q, c_d;
   logic                   hmastlock_q, hmastlock_d;

   logic [NUM_MASTERS:0]   req_ext, lock_ext, mask_ext;
   logic [NUM_MASTERS-1:0] cand;
   logic [MW-1:0]          sel_idx;
   logic                   sel_found, beat, split_hit, retry_hit, arb_pt;

   always_comb begin
      req_ext   = {1'b0, HBUSREQ};
      lock_ext  = {1'b0, HLOCK};
      beat      = (HTRANS == TransNonseq) || (HTRANS == TransSeq);
      split_hit = HREADY && (HRESP == RespSplit);
      retry_hit = HREADY && (HRESP == RespRetry);

      c_d = c_q;
      if (HREADY) begin
         case (HTRANS)
            TransIdle: c_d = 8'd0;
            TransNonseq: begin
               case (HBURST)
                  3'b000:         c_d = 8'd1;
                  3'b001:         c_d = 8'(INCR_MAX_BEATS);
                  3'b010, 3'b011: c_d = 8'd4;
                  3'b100, 3'b101: c_d = 8'd8;
                  default:        c_d = 8'd16;
               endcase
            end
            TransSeq: if (c_q != 8'd0) c_d = c_q - 8'd1;
            default: c_d = c_q;
         endcase
      end
      if (retry_hit) c_d = 8'd0;

      arb_pt = HREADY && ((HTRANS == TransIdle) || (beat && (c_q == 8'd1)) ||
               (!req_ext[g_q] && (HTRANS != TransSeq) && (HTRANS != TransBusy)) ||
               (g_q == Dummy));

      // The master being split is excluded from this very arbitration.
      mask_ext = {1'b0, m_q};
      if (split_hit) mask_ext[hmaster_q] = 1'b1;
      cand = HBUSREQ & ~mask_ext[NUM_MASTERS-1:0];

      sel_found = 1'b0;
      sel_idx   = '0;
      if (ARB_MODE == 0) begin
         for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
               if (!sel_found && cand[i] && ((int'(p_q) + k) % int'(NUM_MASTERS) == i)) begin
                  sel_found = 1'b1;
                  sel_idx   = MW'(i);
               end
            end
         end
      end else begin
         for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!sel_found && cand[i]) begin
               sel_found = 1'b1;
               sel_idx   = MW'(i);
            end
         end
      end

      g_d = g_q;
      p_d = p_q;
      if (split_hit || (arb_pt && !retry_hit)) begin
         if (!split_hit && lock_ext[g_q] && req_ext[g_q]) begin
            g_d = g_q;
         end else if (sel_found) begin
            g_d = sel_idx;
            p_d = sel_idx;
         end else if (!mask_ext[DEFAULT_MASTER]) begin
            g_d = MW'(DEFAULT_MASTER);
         end else begin
            g_d = Dummy;
         end
      end

      // Split-resume wins over a same-cycle split.
      m_d = (mask_ext[NUM_MASTERS-1:0]) & ~HSPLIT;

      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
      if (HREADY) begin
         hmaster_d   = g_q;
         hmastlock_d = lock_ext[g_q];
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         g_q         <= MW'(DEFAULT_MASTER);
         p_q         <= MW'(NUM_MASTERS - 1);
         m_q         <= '0;
         c_q         <= 8'd0;
         hmaster_q   <= MW'(DEFAULT_MASTER);
         hmastlock_q <= 1'b0;
      end else begin
         g_q         <= g_d;
         p_q         <= p_d;
         m_q         <= m_d;
         c_q         <= c_d;
         hmaster_q   <= hmaster_d;
         hmastlock_q <= hmastlock_d;
      end
   end

   always_comb begin
      HGRANT = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) HGRANT[i] = (g_q == MW'(i));
   end

   assign HMASTER   = hmaster_q;
   assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr: a round-robin instance (INCR limit 4) and a
// fixed-priority instance share one stimulus stream; expectations go through a queue.
module tb_ahb_arbiter_rr;

   localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
   localparam logic [1:0] OKAY = 2'b00, RETRY = 2'b10, SPLIT = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR8 = 3'b101, INCR16 = 3'b111;

   logic       HCLK, HRESETn, HREADY;
   logic [3:0] HBUSREQ, HLOCK, HSPLIT;
   logic [1:0] HTRANS, HRESP;
   logic [2:0] HBURST;
   logic [3:0] grant_rr, grant_fp;
   logic [2:0] master_rr, master_fp;
   logic       lock_rr, lock_fp;

   ahb_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(0), .DEFAULT_MASTER(0), .INCR_MAX_BEATS(4))
   u_rr (
      .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
      .HTRANS(HTRANS), .HBURST(HBURST), .HRESP(HRESP), .HREADY(HREADY),
      .HGRANT(grant_rr), .HMASTER(master_rr), .HMASTLOCK(lock_rr)
   );

   ahb_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(1), .DEFAULT_MASTER(0), .INCR_MAX_BEATS(16))
   u_fp (
      .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
      .HTRANS(HTRANS), .HBURST(HBURST), .HRESP(HRESP), .HREADY(HREADY),
      .HGRANT(grant_fp), .HMASTER(master_fp), .HMASTLOCK(lock_fp)
   );

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   function automatic logic [7:0] observe(int sel);
      case (sel)
         0:       return 8'(grant_rr);
         1:       return 8'(master_rr);
         2:       return 8'(lock_rr);
         3:       return 8'(grant_fp);
         4:       return 8'(master_fp);
         default: return 8'(lock_fp);
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic exp_rr(input string tag, input logic [3:0] g, input logic [2:0] m);
      push({tag, ".grant"}, 0, 8'(g));
      push({tag, ".master"}, 1, 8'(m));
   endtask

   task automatic check_sb();
      exp_t       e;
      logic [7:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_tests++;
         assert (obs === e.val)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
      check_sb();
   endtask

   task automatic bus(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                      input logic [2:0] burst, input logic [1:0] resp, input logic ready);
      HBUSREQ = req;
      HLOCK   = lock;
      HTRANS  = trans;
      HBURST  = burst;
      HRESP   = resp;
      HREADY  = ready;
   endtask

   initial begin
      HRESETn = 1'b0;
      HSPLIT  = 4'b0000;
      bus(4'b0000, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      #1;
      exp_rr("reset", 4'b0001, 3'd0);
      push("reset.lock", 2, 8'd0);
      push("reset.fp_grant", 3, 8'h1);
      check_sb();
      @(posedge HCLK);
      @(posedge HCLK);
      #1 HRESETn = 1'b1;

      exp_rr("idle_default", 4'b0001, 3'd0);
      step();

      // Round-robin rotation with SINGLE transfers
      bus(4'b1111, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("rr0", 4'b0001, 3'd0);
      step();
      bus(4'b1111, 4'b0000, NONSEQ, SINGLE, OKAY, 1'b1);
      exp_rr("rr_hold", 4'b0001, 3'd0);
      step();
      exp_rr("rr1", 4'b0010, 3'd0);
      push("fp_single", 3, 8'h1);
      step();
      exp_rr("rr2", 4'b0100, 3'd1);
      step();
      exp_rr("rr3", 4'b1000, 3'd2);
      step();
      exp_rr("rr4", 4'b0001, 3'd3);
      step();
      bus(4'b0000, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("rr_idle", 4'b0001, 3'd0);
      step();

      // RETRY holds the grant even at an IDLE arbitration point
      bus(4'b1111, 4'b0000, IDLE, SINGLE, RETRY, 1'b1);
      exp_rr("retry_hold", 4'b0001, 3'd0);
      step();

      // Fixed priority: lowest index wins, then next after drop
      bus(4'b0110, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      push("fp_0110", 3, 8'h2);
      exp_rr("rr_0110", 4'b0010, 3'd0);
      step();
      bus(4'b0100, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      push("fp_0100", 3, 8'h4);
      exp_rr("rr_0100", 4'b0100, 3'd1);
      step();

      // Locked INCR8 by master 2 while master 0 requests
      bus(4'b0101, 4'b0100, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("lock_keep", 4'b0100, 3'd2);
      push("lock_keep.hmastlock", 2, 8'd1);
      step();
      bus(4'b0101, 4'b0100, NONSEQ, INCR8, OKAY, 1'b1);
      exp_rr("lock_b1", 4'b0100, 3'd2);
      push("lock_b1.hmastlock", 2, 8'd1);
      step();
      for (int b = 2; b <= 8; b++) begin
         bus(4'b0101, 4'b0100, SEQ, INCR8, OKAY, 1'b1);
         exp_rr($sformatf("lock_b%0d", b), 4'b0100, 3'd2);
         push($sformatf("lock_b%0d.hmastlock", b), 2, 8'd1);
         step();
      end
      bus(4'b0001, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("lock_release", 4'b0001, 3'd2);
      push("lock_release.hmastlock", 2, 8'd0);
      step();

      // SPLIT masks master 1 until HSPLIT resumes it
      bus(4'b0010, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("split_g1", 4'b0010, 3'd0);
      step();
      bus(4'b0010, 4'b0000, NONSEQ, SINGLE, OKAY, 1'b1);
      exp_rr("split_addr", 4'b0010, 3'd1);
      step();
      bus(4'b0011, 4'b0000, IDLE, SINGLE, SPLIT, 1'b0);
      exp_rr("split_wait", 4'b0010, 3'd1);
      step();
      bus(4'b0011, 4'b0000, IDLE, SINGLE, SPLIT, 1'b1);
      exp_rr("split_take", 4'b0001, 3'd1);
      step();
      bus(4'b0010, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("split_masked", 4'b0001, 3'd0);
      step();
      HSPLIT = 4'b0010;
      exp_rr("split_resume", 4'b0001, 3'd0);
      step();
      HSPLIT = 4'b0000;
      exp_rr("split_eligible", 4'b0010, 3'd0);
      step();

      // INCR limited to 4 beats, with a 3-cycle wait state in the middle
      bus(4'b0010, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("incr_own", 4'b0010, 3'd1);
      step();
      bus(4'b0110, 4'b0000, NONSEQ, INCR, OKAY, 1'b1);
      exp_rr("incr_b1", 4'b0010, 3'd1);
      step();
      bus(4'b0110, 4'b0000, SEQ, INCR, OKAY, 1'b1);
      exp_rr("incr_b2", 4'b0010, 3'd1);
      step();
      exp_rr("incr_b3", 4'b0010, 3'd1);
      step();
      for (int w = 0; w < 3; w++) begin
         bus(4'b0110, 4'b0000, SEQ, INCR, OKAY, 1'b0);
         exp_rr($sformatf("incr_wait%0d", w), 4'b0010, 3'd1);
         step();
      end
      bus(4'b0110, 4'b0000, SEQ, INCR, OKAY, 1'b1);
      exp_rr("incr_b4", 4'b0010, 3'd1);
      step();
      exp_rr("incr_rearb", 4'b0100, 3'd1);
      step();
      bus(4'b0000, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("incr_idle", 4'b0001, 3'd2);
      step();

      // Split every master: dummy master takes the bus
      bus(4'b1111, 4'b0000, IDLE, SINGLE, SPLIT, 1'b1);
      exp_rr("alls_a", 4'b1000, 3'd0);
      step();
      exp_rr("alls_b", 4'b0010, 3'd3);
      step();
      exp_rr("alls_c", 4'b0010, 3'd1);
      step();
      exp_rr("alls_d", 4'b0000, 3'd1);
      step();
      bus(4'b0000, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("dummy", 4'b0000, 3'd4);
      push("dummy.hmastlock", 2, 8'd0);
      step();

      // Resume all, start a locked INCR16, then reset mid-burst
      HSPLIT = 4'b1111;
      bus(4'b0010, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("resume_all", 4'b0000, 3'd4);
      step();
      HSPLIT = 4'b0000;
      bus(4'b0010, 4'b0010, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("burst_grant", 4'b0010, 3'd4);
      step();
      bus(4'b0010, 4'b0010, NONSEQ, INCR16, OKAY, 1'b1);
      exp_rr("burst_b1", 4'b0010, 3'd1);
      push("burst_b1.hmastlock", 2, 8'd1);
      step();
      bus(4'b0010, 4'b0010, SEQ, INCR16, OKAY, 1'b1);
      exp_rr("burst_b2", 4'b0010, 3'd1);
      push("burst_b2.hmastlock", 2, 8'd1);
      step();
      #3 HRESETn = 1'b0;
      #1;
      exp_rr("async_reset", 4'b0001, 3'd0);
      push("async_reset.hmastlock", 2, 8'd0);
      push("async_reset.fp_grant", 3, 8'h1);
      push("async_reset.fp_master", 4, 8'd0);
      push("async_reset.fp_lock", 5, 8'd0);
      check_sb();
      #2 HRESETn = 1'b1;

      // Round-robin pointer restarts at master 0 after reset
      bus(4'b1001, 4'b0000, IDLE, SINGLE, OKAY, 1'b1);
      exp_rr("post_reset0", 4'b0001, 3'd0);
      step();
      exp_rr("post_reset1", 4'b1000, 3'd0);
      push("post_reset1.fp", 3, 8'h1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
